// File: rtl/keen_decode_stage_if.sv
// Fetch-to-decode handshake, register-file read addresses and the decoded
// instruction bus towards execute.
interface keen_decode_stage_if #(
   parameter int XLEN = 32
);
   localparam int ADDRESS_SIZE = $clog2(XLEN);

   logic                    flush;
   logic                    in_valid;
   logic                    in_ready;
   logic [31:0]             in_instr;
   logic [XLEN-1:0]         in_pc;
   logic [ADDRESS_SIZE-1:0] rs1_address;
   logic [ADDRESS_SIZE-1:0] rs2_address;
   logic                    out_valid;
   logic                    out_ready;
   logic [XLEN-1:0]         out_pc;
   logic [ADDRESS_SIZE-1:0] out_rd;
   logic [XLEN-1:0]         out_imm;
   logic [3:0]              out_funct;
   logic [2:0]              out_class;
   logic                    out_illegal;

   modport slave (
      input  flush, in_valid, in_instr, in_pc, out_ready,
      output in_ready, rs1_address, rs2_address, out_valid, out_pc, out_rd,
             out_imm, out_funct, out_class, out_illegal
   );

   modport master (
      output flush, in_valid, in_instr, in_pc, out_ready,
      input  in_ready, rs1_address, rs2_address, out_valid, out_pc, out_rd,
             out_imm, out_funct, out_class, out_illegal
   );
endinterface

// File: rtl/keen_decode_stage.sv
// RV32I decode stage: one holding register between fetch and execute, with
// register-file read addresses steered so stalled reads stay coherent.
module keen_decode_stage #(
   parameter int XLEN = 32
) (
   input logic                read_clk,
   input logic                reset_clk,
   keen_decode_stage_if.slave bus
);
   localparam int ADDRESS_SIZE = $clog2(XLEN);

   localparam logic [2:0] ClsAluReg = 3'd0;
   localparam logic [2:0] ClsAluImm = 3'd1;
   localparam logic [2:0] ClsLoad   = 3'd2;
   localparam logic [2:0] ClsStore  = 3'd3;
   localparam logic [2:0] ClsBranch = 3'd4;
   localparam logic [2:0] ClsJump   = 3'd5;
   localparam logic [2:0] ClsUpper  = 3'd6;
   localparam logic [2:0] ClsSystem = 3'd7;

   logic [31:0] instr;
   assign instr = bus.in_instr;

   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
   assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8],
                   1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21],
                   1'b0};

   logic [XLEN-1:0] dec_imm;
   logic [2:0]      dec_class;
   logic            dec_illegal;
   logic            uses_rs1;
   logic            uses_rs2;
   logic            writes_rd;

   always_comb begin
      dec_imm     = '0;
      dec_class   = ClsSystem;
      dec_illegal = 1'b1;
      uses_rs1    = 1'b0;
      uses_rs2    = 1'b0;
      writes_rd   = 1'b0;
      if (instr[1:0] == 2'b11) begin
         case (instr[6:2])
            5'b01100: begin
               dec_class = ClsAluReg; dec_illegal = 1'b0;
               uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1;
            end
            5'b00100: begin
               dec_class = ClsAluImm; dec_illegal = 1'b0; dec_imm = imm_i;
               uses_rs1 = 1'b1; writes_rd = 1'b1;
            end
            5'b00000: begin
               dec_class = ClsLoad; dec_illegal = 1'b0; dec_imm = imm_i;
               uses_rs1 = 1'b1; writes_rd = 1'b1;
            end
            5'b01000: begin
               dec_class = ClsStore; dec_illegal = 1'b0; dec_imm = imm_s;
               uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            5'b11000: begin
               dec_class = ClsBranch; dec_illegal = 1'b0; dec_imm = imm_b;
               uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            5'b11011: begin
               dec_class = ClsJump; dec_illegal = 1'b0; dec_imm = imm_j;
               writes_rd = 1'b1;
            end
            5'b11001: begin
               dec_class = ClsJump; dec_illegal = 1'b0; dec_imm = imm_i;
               uses_rs1 = 1'b1; writes_rd = 1'b1;
            end
            5'b01101, 5'b00101: begin
               dec_class = ClsUpper; dec_illegal = 1'b0; dec_imm = imm_u;
               writes_rd = 1'b1;
            end
            5'b11100: begin
               dec_class = ClsSystem; dec_illegal = 1'b0; dec_imm = imm_i;
               uses_rs1 = 1'b1; writes_rd = 1'b1;
            end
            // FENCE keeps class SYSTEM but never writes back
            5'b00011: begin
               dec_class = ClsSystem; dec_illegal = 1'b0; dec_imm = imm_i;
               uses_rs1 = 1'b1;
            end
            default: ;
         endcase
      end
   end

   logic [ADDRESS_SIZE-1:0] dec_rs1, dec_rs2, dec_rd;
   assign dec_rs1 = uses_rs1  ? instr[19:15] : '0;
   assign dec_rs2 = uses_rs2  ? instr[24:20] : '0;
   assign dec_rd  = writes_rd ? instr[11:7]  : '0;

   logic                    valid_q;
   logic [XLEN-1:0]         pc_q;
   logic [ADDRESS_SIZE-1:0] rd_q, rs1_q, rs2_q;
   logic [XLEN-1:0]         imm_q;
   logic [3:0]              funct_q;
   logic [2:0]              class_q;
   logic                    illegal_q;

   logic in_ready;
   logic accept;
   assign in_ready = !reset_clk && !bus.flush && (!valid_q || bus.out_ready);
   assign accept   = bus.in_valid && in_ready;

   always_ff @(posedge read_clk or posedge reset_clk) begin
      if (reset_clk) begin
         valid_q   <= 1'b0;
         pc_q      <= '0;
         rd_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         imm_q     <= '0;
         funct_q   <= '0;
         class_q   <= '0;
         illegal_q <= 1'b0;
      end else if (bus.flush) begin
         valid_q <= 1'b0;
      end else if (accept) begin
         valid_q   <= 1'b1;
         pc_q      <= bus.in_pc;
         rd_q      <= dec_rd;
         rs1_q     <= dec_rs1;
         rs2_q     <= dec_rs2;
         imm_q     <= dec_imm;
         funct_q   <= {instr[30], instr[14:12]};
         class_q   <= dec_class;
         illegal_q <= dec_illegal;
      end else if (bus.out_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign bus.in_ready    = in_ready;
   // Stalled: keep presenting the held operands so register-file data stays aligned
   assign bus.rs1_address = in_ready ? dec_rs1 : rs1_q;
   assign bus.rs2_address = in_ready ? dec_rs2 : rs2_q;
   assign bus.out_valid   = valid_q;
   assign bus.out_pc      = pc_q;
   assign bus.out_rd      = rd_q;
   assign bus.out_imm     = imm_q;
   assign bus.out_funct   = funct_q;
   assign bus.out_class   = class_q;
   assign bus.out_illegal = illegal_q;
endmodule

// File: tb/tb_keen_decode_stage.sv
// Scoreboard bench for keen_decode_stage: hand-decoded instruction table,
// expected entries queued on accept and compared while held at the output.
module tb_keen_decode_stage;
   logic read_clk  = 1'b0;
   logic reset_clk = 1'b1;
   always #5 read_clk = ~read_clk;

   keen_decode_stage_if #(.XLEN(32)) bus ();

   keen_decode_stage #(.XLEN(32)) dut (
      .read_clk  (read_clk),
      .reset_clk (reset_clk),
      .bus       (bus)
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [3:0]  funct;
      logic [2:0]  cls;
      logic        ill;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
   } entry_t;

   localparam int NumEntries = 13;
   entry_t tbl [NumEntries];
   entry_t q[$];
   int     cur = 0;
   int     n_cmp = 0;
   int     n_err = 0;
   int     stall_cycles = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic entry_t mk(input logic [31:0] instr, input logic [4:0] rd,
                                 input logic [31:0] imm, input logic [3:0] funct,
                                 input logic [2:0] cls, input logic ill,
                                 input logic [4:0] rs1, input logic [4:0] rs2);
      entry_t e;
      e.instr = instr; e.pc = '0; e.rd = rd; e.imm = imm; e.funct = funct;
      e.cls = cls; e.ill = ill; e.rs1 = rs1; e.rs2 = rs2;
      return e;
   endfunction

   always @(negedge read_clk) begin
      logic exp_valid, exp_ready;
      exp_valid = (q.size() != 0);
      exp_ready = !reset_clk && !bus.flush && (!exp_valid || bus.out_ready);
      check_val("out_valid", 32'(bus.out_valid), 32'(exp_valid));
      check_val("in_ready", 32'(bus.in_ready), 32'(exp_ready));
      if (exp_valid) begin
         check_val("out_pc", bus.out_pc, q[0].pc);
         check_val("out_rd", 32'(bus.out_rd), 32'(q[0].rd));
         check_val("out_imm", bus.out_imm, q[0].imm);
         check_val("out_funct", 32'(bus.out_funct), 32'(q[0].funct));
         check_val("out_class", 32'(bus.out_class), 32'(q[0].cls));
         check_val("out_illegal", 32'(bus.out_illegal), 32'(q[0].ill));
      end
      if (bus.in_valid && exp_ready) begin
         check_val("rs1_live", 32'(bus.rs1_address), 32'(tbl[cur].rs1));
         check_val("rs2_live", 32'(bus.rs2_address), 32'(tbl[cur].rs2));
      end else if (exp_valid && !exp_ready) begin
         check_val("rs1_held", 32'(bus.rs1_address), 32'(q[0].rs1));
         check_val("rs2_held", 32'(bus.rs2_address), 32'(q[0].rs2));
      end
      if (bus.in_valid && exp_valid && !bus.out_ready && !bus.flush && !reset_clk)
         stall_cycles++;
      if (reset_clk || bus.flush) begin
         q.delete();
      end else begin
         if (exp_valid && bus.out_ready) void'(q.pop_front());
         if (bus.in_valid && exp_ready) q.push_back(tbl[cur]);
      end
   end

   task automatic send(input int idx);
      int   n;
      logic took;
      n = 0;
      took = 1'b0;
      cur = idx;
      bus.in_instr = tbl[idx].instr;
      bus.in_pc    = tbl[idx].pc;
      bus.in_valid = 1'b1;
      while (!took && n < 50) begin
         @(negedge read_clk);
         took = bus.in_ready;
         @(posedge read_clk);
         #1;
         n++;
      end
      bus.in_valid = 1'b0;
      check_val("accept", 32'(took), 32'd1);
   endtask

   task automatic idle(input int cycles);
      repeat (cycles) @(posedge read_clk);
      #1;
   endtask

   task automatic check_zero_outputs(input string tag);
      check_val({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
      check_val({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
      check_val({tag, "_pc"}, bus.out_pc, 32'd0);
      check_val({tag, "_rd"}, 32'(bus.out_rd), 32'd0);
      check_val({tag, "_imm"}, bus.out_imm, 32'd0);
      check_val({tag, "_funct"}, 32'(bus.out_funct), 32'd0);
      check_val({tag, "_class"}, 32'(bus.out_class), 32'd0);
      check_val({tag, "_illegal"}, 32'(bus.out_illegal), 32'd0);
      check_val({tag, "_rs1"}, 32'(bus.rs1_address), 32'd0);
      check_val({tag, "_rs2"}, 32'(bus.rs2_address), 32'd0);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = mk(32'hFFF08293, 5'd5,  32'hFFFFFFFF, 4'h8, 3'd1, 1'b0, 5'd1, 5'd0);
      tbl[1]  = mk(32'h0021A423, 5'd0,  32'h00000008, 4'h2, 3'd3, 1'b0, 5'd3, 5'd2);
      tbl[2]  = mk(32'h002081B3, 5'd3,  32'h00000000, 4'h0, 3'd0, 1'b0, 5'd1, 5'd2);
      tbl[3]  = mk(32'h40628233, 5'd4,  32'h00000000, 4'h8, 3'd0, 1'b0, 5'd5, 5'd6);
      tbl[4]  = mk(32'h123453B7, 5'd7,  32'h12345000, 4'h5, 3'd6, 1'b0, 5'd0, 5'd0);
      tbl[5]  = mk(32'h00209463, 5'd0,  32'h00000008, 4'h1, 3'd4, 1'b0, 5'd1, 5'd2);
      tbl[6]  = mk(32'hFE000FE3, 5'd0,  32'hFFFFFFFE, 4'h8, 3'd4, 1'b0, 5'd0, 5'd0);
      tbl[7]  = mk(32'h010000EF, 5'd1,  32'h00000010, 4'h0, 3'd5, 1'b0, 5'd0, 5'd0);
      tbl[8]  = mk(32'hFFC12503, 5'd10, 32'hFFFFFFFC, 4'hA, 3'd2, 1'b0, 5'd2, 5'd0);
      tbl[9]  = mk(32'h00000000, 5'd0,  32'h00000000, 4'h0, 3'd7, 1'b1, 5'd0, 5'd0);
      tbl[10] = mk(32'h00100092, 5'd0,  32'h00000000, 4'h0, 3'd7, 1'b1, 5'd0, 5'd0);
      tbl[11] = mk(32'h0FF0008F, 5'd0,  32'h000000FF, 4'h0, 3'd7, 1'b0, 5'd0, 5'd0);
      tbl[12] = mk(32'h00000073, 5'd0,  32'h00000000, 4'h0, 3'd7, 1'b0, 5'd0, 5'd0);
      for (int i = 0; i < NumEntries; i++) tbl[i].pc = 32'h1000 + 32'(i * 4);

      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_instr  = '0;
      bus.in_pc     = '0;
      bus.out_ready = 1'b1;
      #1;
      check_zero_outputs("reset");
      idle(2);
      reset_clk = 1'b0;
      idle(1);

      // Full-rate stream through every instruction format
      for (int i = 0; i < NumEntries; i++) send(i);
      idle(2);

      // Downstream stall for five cycles with fetch pushing behind it
      send(0);
      bus.out_ready = 1'b0;
      stall_cycles = 0;
      fork
         send(1);
         begin
            repeat (5) @(posedge read_clk);
            #1 bus.out_ready = 1'b1;
         end
      join
      check_val("stall_cycles", 32'(stall_cycles), 32'd5);
      send(2);
      send(3);
      idle(3);

      // Flush while holding and while fetch presents
      bus.out_ready = 1'b0;
      send(4);
      cur = 5;
      bus.in_instr = tbl[5].instr;
      bus.in_pc    = tbl[5].pc;
      bus.in_valid = 1'b1;
      bus.flush    = 1'b1;
      idle(1);
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge read_clk);
      check_val("flush_valid", 32'(bus.out_valid), 32'd0);
      idle(1);
      bus.out_ready = 1'b1;
      idle(1);

      // Asynchronous reset in the middle of a stall
      bus.out_ready = 1'b0;
      send(6);
      cur = 7;
      bus.in_instr = tbl[7].instr;
      bus.in_pc    = tbl[7].pc;
      bus.in_valid = 1'b1;
      idle(2);
      #2 reset_clk = 1'b1;
      q.delete();
      #1;
      check_zero_outputs("async_rst");
      bus.in_valid = 1'b0;
      idle(2);
      reset_clk = 1'b0;
      bus.out_ready = 1'b1;
      idle(1);
      send(7);
      send(8);
      idle(3);
      check_val("drain", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
